multicycle_cu: RTL and testbench



---
 rtl/multicycle_cu.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_cu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: Moore FSM sequencing PC, IR, register file, ALU and
// unified memory through fetch/decode/execute/memory/write-back steps.
module multicycle_cu #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MDRW,
    output logic             ALUM2Reg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             RegWrite,
    output logic             RegOut,
    output logic [1:0]       PCSrc,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
    } state_t;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_ADDI = 6'd3;
    localparam logic [5:0] OP_LW   = 6'd4;
    localparam logic [5:0] OP_SW   = 6'd5;
    localparam logic [5:0] OP_BEQ  = 6'd6;
    localparam logic [5:0] OP_J    = 6'd7;

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;
    logic             w_unused;

    // The branch condition is applied in the datapath, so zero is not consumed here.
    assign w_unused = zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // mem_ready handshake: an access started in FETCH, MEM_RD or MEM_WR is held
    // (same state, same outputs) until mem_ready=1 completes it in that cycle;
    // in every other state mem_ready has no effect.
    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        IorD        = 1'b0;
        MDRW        = 1'b0;
        ALUM2Reg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        RegWrite    = 1'b0;
        RegOut      = 1'b0;
        PCSrc       = 2'b00;
        illegal     = 1'b0;

        case (r_state)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_NOP: begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    OP_ADD, OP_SUB: w_next = S_EXEC_R;
                    OP_ADDI:        w_next = S_EXEC_I;
                    OP_LW, OP_SW:   w_next = S_MEM_ADDR;
                    OP_BEQ:         w_next = S_BRANCH;
                    OP_J:           w_next = S_JUMP;
                    default: begin
                        w_next  = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = (opcode == OP_SUB) ? 3'b001 : 3'b000;
                w_next  = S_WB_ALU;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                IorD = 1'b1;
                if (mem_ready) begin
                    w_next = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                IorD = 1'b1;
                MDRW = 1'b1;
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                RegOut   = (opcode == OP_ADD) || (opcode == OP_SUB);
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                ALUM2Reg = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCSrc       = 2'b01;
                PCWriteCond = 1'b1;
                w_next      = S_FETCH;
                w_retire    = 1'b1;
            end
            S_JUMP: begin
                PCSrc    = 2'b10;
                PCWrite  = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset silences every enable at once, before any clock edge.
        if (rst) begin
            w_retire    = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            IorD        = 1'b0;
            MDRW        = 1'b0;
            ALUM2Reg    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 3'b000;
            RegWrite    = 1'b0;
            RegOut      = 1'b0;
            PCSrc       = 2'b00;
            illegal     = 1'b0;
        end
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: per-instruction expected cycle sequences built from
// the opcode rules, compared every cycle against state, controls and retired.
module tb_multicycle_cu;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IRWrite, IorD, MDRW, ALUM2Reg, ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUOp;
    logic             RegWrite, RegOut;
    logic [1:0]       PCSrc;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    multicycle_cu #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite), .IorD(IorD),
        .MDRW(MDRW), .ALUM2Reg(ALUM2Reg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .RegWrite(RegWrite), .RegOut(RegOut), .PCSrc(PCSrc),
        .state(state), .illegal(illegal), .retired(retired)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] w_ctl;
    assign w_ctl = {PCWrite, PCWriteCond, IRWrite, IorD, MDRW, ALUM2Reg, ALUSrcA,
                    ALUSrcB, ALUOp, RegWrite, RegOut, PCSrc, illegal};

    int          n_chk = 0;
    int          n_err = 0;
    int          ret_exp = 0;
    logic [21:0] exp_q[$];   // {state[3:0], mem_ready to drive, ctl[16:0]}

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] mk(input logic pcw, input logic pcwc, input logic irw,
                                       input logic iord, input logic mdrw, input logic m2r,
                                       input logic srca, input logic [1:0] srcb,
                                       input logic [2:0] aop, input logic regw,
                                       input logic regout, input logic [1:0] pcsrc,
                                       input logic ill);
        return {pcw, pcwc, irw, iord, mdrw, m2r, srca, srcb, aop, regw, regout, pcsrc, ill};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [3:0] st, input logic mr, input logic [16:0] c);
        exp_q.push_back({st, mr, c});
    endtask

    // ---- reference model: expected cycle list for one instruction ----
    task automatic build(input logic [5:0] op, input int fw, input int mw, output logic ret);
        exp_q.delete();
        for (int i = 0; i < fw; i++) push(4'd0, 1'b0, mk(0,0,0,0,0,0,0,2'b01,3'd0,0,0,2'b00,0));
        push(4'd0, 1'b1, mk(1,0,1,0,0,0,0,2'b01,3'd0,0,0,2'b00,0));
        push(4'd1, rb(), mk(0,0,0,0,0,0,0,2'b11,3'd0,0,0,2'b00,(op > 6'd7)));
        ret = (op <= 6'd7);
        case (op)
            6'd1, 6'd2: begin
                push(4'd2, rb(), mk(0,0,0,0,0,0,1,2'b00,(op == 6'd2) ? 3'd1 : 3'd0,0,0,2'b00,0));
                push(4'd7, rb(), mk(0,0,0,0,0,0,0,2'b00,3'd0,1,1,2'b00,0));
            end
            6'd3: begin
                push(4'd3, rb(), mk(0,0,0,0,0,0,1,2'b10,3'd0,0,0,2'b00,0));
                push(4'd7, rb(), mk(0,0,0,0,0,0,0,2'b00,3'd0,1,0,2'b00,0));
            end
            6'd4: begin
                push(4'd4, rb(), mk(0,0,0,0,0,0,1,2'b10,3'd0,0,0,2'b00,0));
                for (int i = 0; i < mw; i++) push(4'd5, 1'b0, mk(0,0,0,1,0,0,0,2'b00,3'd0,0,0,2'b00,0));
                push(4'd5, 1'b1, mk(0,0,0,1,0,0,0,2'b00,3'd0,0,0,2'b00,0));
                push(4'd8, rb(), mk(0,0,0,0,0,1,0,2'b00,3'd0,1,0,2'b00,0));
            end
            6'd5: begin
                push(4'd4, rb(), mk(0,0,0,0,0,0,1,2'b10,3'd0,0,0,2'b00,0));
                for (int i = 0; i < mw; i++) push(4'd6, 1'b0, mk(0,0,0,1,1,0,0,2'b00,3'd0,0,0,2'b00,0));
                push(4'd6, 1'b1, mk(0,0,0,1,1,0,0,2'b00,3'd0,0,0,2'b00,0));
            end
            6'd6: push(4'd9, rb(), mk(0,1,0,0,0,0,1,2'b00,3'd1,0,0,2'b01,0));
            6'd7: push(4'd10, rb(), mk(1,0,0,0,0,0,0,2'b00,3'd0,0,0,2'b10,0));
            default: ;
        endcase
    endtask

    // ---- driver: one instruction, checked every cycle ----
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
        logic        ret;
        logic [21:0] e;
        int          cyc;
        build(op, fw, mw, ret);
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            opcode    = op;
            zero      = z;
            mem_ready = e[17];
            #1;
            check_eq($sformatf("state op=%0h c%0d", op, cyc), 32'(state), 32'(e[21:18]));
            check_eq($sformatf("ctl op=%0h c%0d", op, cyc), 32'(w_ctl), 32'(e[16:0]));
            check_eq($sformatf("retired op=%0h c%0d", op, cyc), 32'(retired), 32'(ret_exp));
            cyc++;
        end
        if (ret) ret_exp = (ret_exp + 1) % (1 << CNT_W);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'($urandom_range(0, 63));
        @(negedge clk);
        #1;
        check_eq("rst state", 32'(state), 32'd0);
        check_eq("rst ctl", 32'(w_ctl), 32'd0);
        check_eq("rst retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b0;
        ret_exp   = 0;
    endtask

    task automatic reset_mid_exec();
        @(negedge clk);
        opcode    = 6'd1;
        mem_ready = 1'b1;
        #1 check_eq("abort fetch", 32'(state), 32'd0);
        @(negedge clk);
        #1 check_eq("abort decode", 32'(state), 32'd1);
        @(negedge clk);
        #1 check_eq("abort exec_r", 32'(state), 32'd2);
        check_eq("abort pre retired", 32'(retired), 32'(ret_exp));
        #1 rst = 1'b1;
        #1;
        check_eq("abort state", 32'(state), 32'd0);
        check_eq("abort ctl", 32'(w_ctl), 32'd0);
        check_eq("abort retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b0;
        ret_exp   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        opcode    = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        do_reset();

        // directed scenarios
        run_instr(6'd1, 0, 0, 1'b0);   // ADD
        run_instr(6'd4, 0, 2, 1'b0);   // LW, two MEM_RD waits
        run_instr(6'd5, 0, 3, 1'b1);   // SW, three MEM_WR waits
        run_instr(6'd6, 0, 0, 1'b1);   // BEQ taken
        run_instr(6'd6, 0, 0, 1'b0);   // BEQ not taken
        run_instr(6'd63, 0, 0, 1'b0);  // illegal
        run_instr(6'd7, 0, 0, 1'b0);   // J
        run_instr(6'd2, 2, 0, 1'b0);   // SUB with fetch waits
        run_instr(6'd3, 1, 0, 1'b1);   // ADDI

        // randomized mix, including illegal opcodes and wait states
        for (int i = 0; i < 60; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(8, 63)) : 6'($urandom_range(0, 7));
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
        end

        reset_mid_exec();

        // counter wrap: 16 NOPs bring a 4-bit count back to 0
        for (int i = 0; i < 16; i++) run_instr(6'd0, 0, 0, rb());
        @(negedge clk);
        mem_ready = 1'b0;
        #1 check_eq("wrap retired", 32'(retired), 32'd0);
        check_eq("wrap model", 32'(retired), 32'(ret_exp));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
